// File: rtl/multi_cycle_control_pkg.sv
// Shared constants for the multi-cycle instruction controller: opcodes,
// FSM state encoding and ALU operation classes.
package multi_cycle_control_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_NONE  = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

endpackage

// File: rtl/multi_cycle_control_decode.sv
// Combinational opcode decoder: maps an opcode to its ALU operation class,
// operand source select and a legal flag.
module opcode_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       legal
);

    always_comb begin
        alu_op  = ALUOP_NONE;
        alu_src = 1'b0;
        legal   = 1'b0;
        case (opcode)
            R_TYPE: begin
                alu_op  = ALUOP_RTYPE;
                alu_src = 1'b0;
                legal   = 1'b1;
            end
            I_TYPE: begin
                alu_op  = ALUOP_ITYPE;
                alu_src = 1'b1;
                legal   = 1'b1;
            end
            default: begin
                alu_op  = ALUOP_NONE;
                alu_src = 1'b0;
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXECUTE/WRITEBACK).
// Define CTRL_PERF_CNT_EN to build the 32-bit retired-instruction counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | stopped, waiting for start_i
// FETCH     | waiting for mem_ready_i, then loads PC and IR
// DECODE    | latches Op_i; illegal opcodes pulse illegal_o and skip
// EXECUTE   | ALU controls driven from the latched opcode
// WRITEBACK | one RegWrite_o pulse, retire, then FETCH or IDLE
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  Op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        IRWrite_o,
    output logic [1:0]  ALUOp_o,
    output logic        ALUSrc_o,
    output logic        RegWrite_o,
    output logic        busy_o,
    output logic        illegal_o,
    output logic [31:0] retire_cnt_o
);

    state_t     state;
    logic [6:0] opcode_q;
    logic       busy_q;
    logic       reg_write_q;

    logic [6:0] dec_opcode;
    logic [1:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_legal;
    logic       alu_active;

    // Op_i is only looked at while in DECODE; elsewhere the latched copy is used,
    // so an unknown Op_i outside DECODE cannot reach any output.
    assign dec_opcode = (state == ST_DECODE) ? Op_i : opcode_q;

    opcode_decode u_decode (
        .opcode  (dec_opcode),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            opcode_q    <= '0;
            busy_q      <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    reg_write_q <= 1'b0;
                    if (start_i) begin
                        state  <= ST_FETCH;
                        busy_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    opcode_q <= Op_i;
                    if (dec_legal) begin
                        state <= ST_EXECUTE;
                    end else if (start_i) begin
                        state <= ST_FETCH;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_EXECUTE: begin
                    state       <= ST_WRITEBACK;
                    reg_write_q <= 1'b1;
                end
                ST_WRITEBACK: begin
                    reg_write_q <= 1'b0;
                    if (start_i) begin
                        state <= ST_FETCH;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy_q      <= 1'b0;
                    reg_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_active = (state == ST_EXECUTE) || (state == ST_WRITEBACK);

    assign PCWrite_o  = (state == ST_FETCH) && mem_ready_i;
    assign IRWrite_o  = (state == ST_FETCH) && mem_ready_i;
    assign ALUOp_o    = alu_active ? dec_alu_op : ALUOP_NONE;
    assign ALUSrc_o   = alu_active ? dec_alu_src : 1'b0;
    assign RegWrite_o = reg_write_q;
    assign busy_o     = busy_q;
    assign illegal_o  = (state == ST_DECODE) && !dec_legal;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retire_cnt_q <= '0;
        end else if (state == ST_WRITEBACK) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed, table-driven bench for multi_cycle_control plus hand-written
// sequences for reset mid-instruction and retire counter wrap.
module tb_multi_cycle_control;
    import multi_cycle_control_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [6:0]  Op_i;
    logic        mem_ready_i;
    logic        PCWrite_o;
    logic        IRWrite_o;
    logic [1:0]  ALUOp_o;
    logic        ALUSrc_o;
    logic        RegWrite_o;
    logic        busy_o;
    logic        illegal_o;
    logic [31:0] retire_cnt_o;

    int total = 0;
    int bad   = 0;

    multi_cycle_control dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .Op_i         (Op_i),
        .mem_ready_i  (mem_ready_i),
        .PCWrite_o    (PCWrite_o),
        .IRWrite_o    (IRWrite_o),
        .ALUOp_o      (ALUOp_o),
        .ALUSrc_o     (ALUSrc_o),
        .RegWrite_o   (RegWrite_o),
        .busy_o       (busy_o),
        .illegal_o    (illegal_o),
        .retire_cnt_o (retire_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Output bundle order: {PCWrite, IRWrite, ALUOp[1:0], ALUSrc, RegWrite, busy, illegal}
    typedef struct {
        logic       start;
        logic [6:0] op;
        logic       ready;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[23];

    function automatic logic [7:0] outs();
        return {PCWrite_o, IRWrite_o, ALUOp_o, ALUSrc_o, RegWrite_o, busy_o, illegal_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    logic [31:0] exp_cnt;

    initial begin
        // IDLE: start -> FETCH
        vecs[0]  = '{1'b1, 7'h00,   1'b1, 8'b0_0_00_0_0_0_0};
        // R-type, zero-wait fetch
        vecs[1]  = '{1'b1, R_TYPE,  1'b1, 8'b1_1_00_0_0_1_0};
        vecs[2]  = '{1'b1, R_TYPE,  1'b1, 8'b0_0_00_0_0_1_0};
        vecs[3]  = '{1'b1, 7'h00,   1'b1, 8'b0_0_00_0_0_1_0};
        vecs[4]  = '{1'b1, 7'h7F,   1'b1, 8'b0_0_00_0_1_1_0};
        // I-type, three wait cycles in FETCH
        vecs[5]  = '{1'b1, 7'h00,   1'b0, 8'b0_0_00_0_0_1_0};
        vecs[6]  = '{1'b1, 7'h00,   1'b0, 8'b0_0_00_0_0_1_0};
        vecs[7]  = '{1'b1, 7'h00,   1'b0, 8'b0_0_00_0_0_1_0};
        vecs[8]  = '{1'b1, 7'h00,   1'b1, 8'b1_1_00_0_0_1_0};
        vecs[9]  = '{1'b1, I_TYPE,  1'b1, 8'b0_0_00_0_0_1_0};
        vecs[10] = '{1'b1, 7'h00,   1'b1, 8'b0_0_10_1_0_1_0};
        vecs[11] = '{1'b1, 7'h00,   1'b1, 8'b0_0_10_1_1_1_0};
        // illegal opcode with start held: back to FETCH
        vecs[12] = '{1'b1, 7'h00,   1'b1, 8'b1_1_00_0_0_1_0};
        vecs[13] = '{1'b1, 7'b0000011, 1'b1, 8'b0_0_00_0_0_1_1};
        vecs[14] = '{1'b1, 7'h00,   1'b1, 8'b1_1_00_0_0_1_0};
        // R-type with start dropped in EXECUTE: completes, then IDLE
        vecs[15] = '{1'b1, R_TYPE,  1'b1, 8'b0_0_00_0_0_1_0};
        vecs[16] = '{1'b0, 7'h00,   1'b1, 8'b0_0_00_0_0_1_0};
        vecs[17] = '{1'b0, 7'h00,   1'b1, 8'b0_0_00_0_1_1_0};
        vecs[18] = '{1'b0, 7'h00,   1'b1, 8'b0_0_00_0_0_0_0};
        // illegal opcode with start low: back to IDLE
        vecs[19] = '{1'b1, 7'h00,   1'b1, 8'b0_0_00_0_0_0_0};
        vecs[20] = '{1'b0, 7'h00,   1'b1, 8'b1_1_00_0_0_1_0};
        vecs[21] = '{1'b0, 7'h7F,   1'b1, 8'b0_0_00_0_0_1_1};
        vecs[22] = '{1'b0, 7'h00,   1'b1, 8'b0_0_00_0_0_0_0};

        rst_i       = 1'b0;
        start_i     = 1'b0;
        Op_i        = 7'h00;
        mem_ready_i = 1'b0;
        exp_cnt     = 32'd0;

        #12;
        check("reset_outputs", {24'd0, outs()}, 32'd0);
        check("reset_retire", retire_cnt_o, 32'd0);

        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk_i);
            start_i     = vecs[i].start;
            Op_i        = vecs[i].op;
            mem_ready_i = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_outputs", i), {24'd0, outs()}, {24'd0, vecs[i].exp});
            check($sformatf("vec%0d_retire", i), retire_cnt_o, exp_cnt);
`ifdef CTRL_PERF_CNT_EN
            if (vecs[i].exp[2]) exp_cnt = exp_cnt + 32'd1;
`endif
        end

        // Reset asserted mid-EXECUTE
        @(negedge clk_i);
        start_i = 1'b1; Op_i = R_TYPE; mem_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        Op_i = 7'h00;
        #1;
        check("exec_before_reset", {24'd0, outs()}, {24'd0, 8'b0_0_00_0_0_1_0});
        #1;
        rst_i = 1'b0;
        #1;
        check("reset_mid_exec_outputs", {24'd0, outs()}, 32'd0);
        check("reset_mid_exec_retire", retire_cnt_o, 32'd0);
        @(posedge clk_i);
        #1;
        check("reset_held_no_regwrite", {24'd0, outs()}, 32'd0);

        // After reset release, stay idle until start
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("post_reset_idle%0d", k), {24'd0, outs()}, 32'd0);
        end

        exp_cnt = 32'd0;
`ifdef CTRL_PERF_CNT_EN
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check("preload_retire", retire_cnt_o, 32'hFFFF_FFFF);
`endif

        // Two R-type instructions back to back; counter wraps then steps
        @(negedge clk_i);
        start_i = 1'b1; Op_i = R_TYPE; mem_ready_i = 1'b1;
        #1;
        check("restart_idle", {24'd0, outs()}, 32'd0);
        @(negedge clk_i);
        #1;
        check("restart_fetch", {24'd0, outs()}, {24'd0, 8'b1_1_00_0_0_1_0});
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("restart_wb", {24'd0, outs()}, {24'd0, 8'b0_0_00_0_1_1_0});
        @(negedge clk_i);
        #1;
        check("wrap_retire", retire_cnt_o, exp_cnt);
        @(negedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("second_wb", {24'd0, outs()}, {24'd0, 8'b0_0_00_0_1_1_0});
        @(negedge clk_i);
        #1;
`ifdef CTRL_PERF_CNT_EN
        exp_cnt = 32'd1;
`endif
        check("after_wrap_retire", retire_cnt_o, exp_cnt);
        check("final_idle", {24'd0, outs()}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port start_i, input, 1 bit: run enable, sampled at each rising edge.
REQ-004 The block SHALL have port Op_i, input, 7 bits: opcode field of the instruction-register output.
REQ-005 The block SHALL have port mem_ready_i, input, 1 bit: instruction memory data valid.
REQ-006 The block SHALL have port PCWrite_o, output, 1 bit: PC register load enable.
REQ-007 The block SHALL have port IRWrite_o, output, 1 bit: instruction register load enable.
REQ-008 The block SHALL have port ALUOp_o, output, 2 bits: ALU operation class.
REQ-009 The block SHALL have port ALUSrc_o, output, 1 bit: 0 selects register operand, 1 selects immediate.
REQ-010 The block SHALL have port RegWrite_o, output, 1 bit: register file write enable.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port illegal_o, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-013 The block SHALL have port retire_cnt_o, output, 32 bits: count of retired instructions.

Function
REQ-014 The block SHALL implement the FSM states IDLE, FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-015 IDLE SHALL go to FETCH on a rising edge with start_i=1 and otherwise stay in IDLE.
REQ-016 FETCH SHALL hold while mem_ready_i=0; in the cycle mem_ready_i=1 it SHALL assert PCWrite_o=1 and IRWrite_o=1 combinationally and go to DECODE on the next edge.
REQ-017 DECODE SHALL latch Op_i into an internal opcode register.
REQ-018 On R-type opcode 0110011 or I-type opcode 0010011, DECODE SHALL go to EXECUTE.
REQ-019 On any other opcode, DECODE SHALL assert illegal_o for exactly that cycle and go to FETCH, or to IDLE if start_i=0, without any RegWrite_o.
REQ-020 In EXECUTE and WRITEBACK, ALUOp_o and ALUSrc_o SHALL reflect the latched opcode: R-type gives 00/0, I-type gives 10/1; in all other states both SHALL be 0.
REQ-021 WRITEBACK SHALL assert RegWrite_o for exactly one cycle, increment retire_cnt_o by 1 (modulo 2^32, wrapping 0xFFFFFFFF to 0), then go to FETCH if start_i=1, else to IDLE.
REQ-022 Deasserting start_i mid-instruction SHALL NOT abort it; the instruction SHALL complete, then the FSM SHALL enter IDLE.
REQ-023 Minimum instruction latency SHALL be 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK) with mem_ready_i=1 in FETCH.
REQ-024 RegWrite_o, PCWrite_o and IRWrite_o SHALL never be asserted in the same cycle.
REQ-025 X or unknown Op_i SHALL only be sampled in DECODE; Op_i SHALL be ignored in all other states.

Reset
REQ-026 rst_i=0 SHALL immediately force IDLE, clear the opcode register and clear retire_cnt_o to 0, regardless of the clock.
REQ-027 During reset, all outputs SHALL be 0.
REQ-028 Reset asserted mid-instruction SHALL suppress any pending RegWrite_o and PCWrite_o.
REQ-029 After rst_i returns to 1, the first transition SHALL occur at the first rising edge with start_i=1.

Configuration
REQ-030 Macro CTRL_PERF_CNT_EN: when defined, the block SHALL implement the 32-bit retire counter.
REQ-031 When CTRL_PERF_CNT_EN is undefined, retire_cnt_o SHALL be tied to 0 and no counter flops SHALL be inferred; all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold the opcode constants R_TYPE=7'b0110011 and I_TYPE=7'b0010011.
REQ-033 The shared package SHALL hold the FSM state encoding (3 bits: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4).
REQ-034 The shared package SHALL hold the ALUOp encodings.
REQ-035 The block SHALL contain one combinational sub-module, opcode_decode, that maps the latched opcode to ALUOp, ALUSrc and a legal flag.

Verification
REQ-036 Reset then start_i=1 with mem_ready_i=1 and Op_i=0110011 -> PCWrite_o/IRWrite_o high in cycle 1; ALUOp_o=00, ALUSrc_o=0 in cycles 3-4; RegWrite_o high in cycle 4 only; retire_cnt_o=1.
REQ-037 I-type 0010011 with mem_ready_i low for 3 cycles -> FETCH holds 3 extra cycles; ALUOp_o=10, ALUSrc_o=1; RegWrite_o single pulse at cycle 7.
REQ-038 Op_i=0000011 -> illegal_o pulses 1 cycle in DECODE, no RegWrite_o, retire_cnt_o unchanged, next state FETCH.
REQ-039 start_i dropped during EXECUTE -> WRITEBACK completes, then IDLE with busy_o=0 and no further PCWrite_o.
REQ-040 rst_i low mid-EXECUTE -> all outputs 0 immediately, retire_cnt_o=0, IDLE.
REQ-041 With CTRL_PERF_CNT_EN and the counter preloaded to 0xFFFFFFFF by force -> after one retire, retire_cnt_o=0.
